// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding and the special scan-code bytes.
package ps2_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  function automatic logic ps2_is_err(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code consumer: pops bytes from the receiver FIFO, decodes E0/F0 prefixes
// and tracks a single held key with press/release strobes and a press counter.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  input  logic             clr_stat,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen
);

  ps2_state_e       state_q;
  logic             nextdata_n_q;
  logic [7:0]       key_code_q;
  logic             key_ext_q;
  logic             key_down_q;
  logic             press_pulse_q;
  logic             release_pulse_q;
  logic             brk_pend_q;
  logic             ext_pend_q;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             ovf_seen_q, ovf_seen_d;

  logic is_break_byte;
  logic is_ext_byte;
  logic is_err_byte;
  logic same_key;
  logic new_make;
  logic match_break;

  // Byte classification against the currently held key.
  always_comb begin
    is_break_byte = (data == PS2_BREAK);
    is_ext_byte   = (data == PS2_EXT);
    is_err_byte   = ps2_is_err(data);
    same_key      = (data == key_code_q) && (ext_pend_q == key_ext_q);
    new_make      = !key_down_q || !same_key;
    match_break   = key_down_q && same_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WAIT;
      nextdata_n_q    <= 1'b1;
      key_code_q      <= 8'h00;
      key_ext_q       <= 1'b0;
      key_down_q      <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      brk_pend_q      <= 1'b0;
      ext_pend_q      <= 1'b0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      nextdata_n_q    <= 1'b1;
      case (state_q)
        WAIT: begin
          if (ready) begin
            state_q      <= POP;
            nextdata_n_q <= 1'b0;
            if (is_break_byte) begin
              brk_pend_q <= 1'b1;
            end else if (is_ext_byte) begin
              ext_pend_q <= 1'b1;
            end else begin
              brk_pend_q <= 1'b0;
              ext_pend_q <= 1'b0;
              if (!is_err_byte) begin
                if (!brk_pend_q) begin
                  // Typematic repeats of the held key fall through silently.
                  if (new_make) begin
                    key_code_q    <= data;
                    key_ext_q     <= ext_pend_q;
                    key_down_q    <= 1'b1;
                    press_pulse_q <= 1'b1;
                  end
                end else if (match_break) begin
                  key_down_q      <= 1'b0;
                  release_pulse_q <= 1'b1;
                end
              end
            end
          end
        end
        POP:     state_q <= GAP;
        GAP:     state_q <= WAIT;
        default: state_q <= WAIT;
      endcase
    end
  end

  // Statistics: the count follows the registered pulse, so a clear in the pulse cycle wins.
  always_comb begin
    press_cnt_d = press_cnt_q;
    ovf_seen_d  = ovf_seen_q;
    if (clr_stat) begin
      press_cnt_d = '0;
      ovf_seen_d  = 1'b0;
    end else begin
      if (press_pulse_q) press_cnt_d = press_cnt_q + CNT_W'(1);
      if (overflow)      ovf_seen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt_q <= '0;
      ovf_seen_q  <= 1'b0;
    end else begin
      press_cnt_q <= press_cnt_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end

  assign nextdata_n    = nextdata_n_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign key_down      = key_down_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_cnt     = press_cnt_q;
  assign ovf_seen      = ovf_seen_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a small FIFO model answering the pop strobe.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       clr_stat;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_cnt;
  logic       ovf_seen;

  ps2_key_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow),
    .clr_stat(clr_stat), .nextdata_n(nextdata_n), .key_code(key_code),
    .key_ext(key_ext), .key_down(key_down), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .press_cnt(press_cnt), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int n_pops = 0;
  int n_press = 0;
  int n_rel = 0;
  int pop_cyc [0:1023];
  logic [7:0] press_code [0:1023];

  int n_assert = 0;
  int n_fail = 0;

  // FIFO model: pops on each low cycle of nextdata_n, then presents the new head.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (nextdata_n === 1'b0) begin
      pop_cyc[n_pops] = cyc;
      n_pops = n_pops + 1;
      rd_ptr = rd_ptr + 1;
    end
    if (press_pulse === 1'b1) begin
      press_code[n_press] = key_code;
      n_press = n_press + 1;
    end
    if (release_pulse === 1'b1) n_rel = n_rel + 1;
    ready = (rd_ptr != wr_ptr);
    data  = mem[rd_ptr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (rd_ptr != wr_ptr && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (rd_ptr != wr_ptr) chk("idle_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s_pop, s_pr, s_rel, t;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; overflow = 1'b0; clr_stat = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_key_code",   32'(key_code),   32'd0);
    chk("rst_key_down",   32'(key_down),   32'd0);
    chk("rst_key_ext",    32'(key_ext),    32'd0);
    chk("rst_pulses",     32'({press_pulse, release_pulse}), 32'd0);
    chk("rst_press_cnt",  32'(press_cnt),  32'd0);
    chk("rst_ovf_seen",   32'(ovf_seen),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 15, F0, 15
    s_pop = n_pops; s_pr = n_press; s_rel = n_rel;
    push(8'h15);
    wait_idle();
    chk("t1_code",  32'(key_code), 32'h15);
    chk("t1_ext",   32'(key_ext),  32'd0);
    chk("t1_down",  32'(key_down), 32'd1);
    push(8'hF0); push(8'h15);
    wait_idle();
    chk("t1_up",    32'(key_down), 32'd0);
    chk("t1_keep",  32'(key_code), 32'h15);
    chk("t1_press", 32'(n_press - s_pr),  32'd1);
    chk("t1_rel",   32'(n_rel - s_rel),   32'd1);
    chk("t1_pops",  32'(n_pops - s_pop),  32'd3);
    chk("t1_cnt",   32'(press_cnt), 32'd1);

    // Typematic: 1C x3, F0, 1C
    pulse_clr();
    chk("clr_cnt", 32'(press_cnt), 32'd0);
    s_pr = n_press; s_rel = n_rel;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    wait_idle();
    chk("t2_cnt",   32'(press_cnt), 32'd1);
    chk("t2_press", 32'(n_press - s_pr), 32'd1);
    chk("t2_rel",   32'(n_rel - s_rel),  32'd1);

    // Extended: E0 75, E0 F0 75, then plain 75
    s_pr = n_press; s_rel = n_rel;
    push(8'hE0); push(8'h75);
    wait_idle();
    chk("t3_code", 32'(key_code), 32'h75);
    chk("t3_ext",  32'(key_ext),  32'd1);
    chk("t3_down", 32'(key_down), 32'd1);
    push(8'hE0); push(8'hF0); push(8'h75);
    wait_idle();
    chk("t3_up",     32'(key_down), 32'd0);
    chk("t3_extkep", 32'(key_ext),  32'd1);
    chk("t3_rel",    32'(n_rel - s_rel), 32'd1);
    push(8'h75);
    wait_idle();
    chk("t3_plain_ext",  32'(key_ext),  32'd0);
    chk("t3_plain_down", 32'(key_down), 32'd1);
    chk("t3_press",      32'(n_press - s_pr), 32'd2);
    // Error byte drops a pending break prefix
    push(8'hF0); push(8'h00); push(8'h75);
    wait_idle();
    chk("t3_err_down", 32'(key_down), 32'd1);

    // Back-to-back queue: one pop every 3 cycles, no skip or double read
    pulse_clr();
    s_pop = n_pops; s_pr = n_press;
    push(8'h30); push(8'h31); push(8'h32); push(8'h33);
    wait_idle();
    chk("t4_pops", 32'(n_pops - s_pop), 32'd4);
    for (int i = 0; i < 3; i++)
      chk("t4_spacing", 32'(pop_cyc[s_pop+i+1] - pop_cyc[s_pop+i]), 32'd3);
    for (int i = 0; i < 4; i++)
      chk("t4_order", 32'(press_code[s_pr+i]), 32'h30 + 32'(i));
    chk("t4_cnt", 32'(press_cnt), 32'd4);

    // Counter wrap
    pulse_clr();
    s_pr = n_press;
    for (int i = 0; i < 255; i++) push((i % 2 == 0) ? 8'h10 : 8'h11);
    wait_idle();
    chk("t5_cnt255", 32'(press_cnt), 32'd255);
    push(8'h23);
    wait_idle();
    chk("t5_wrap",  32'(press_cnt), 32'd0);
    chk("t5_press", 32'(n_press - s_pr), 32'd256);

    // clr_stat in the press_pulse cycle
    push(8'h24);
    t = 0;
    @(negedge clk);
    while (press_pulse !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t6_pulse_seen", 32'(press_pulse), 32'd1);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    wait_idle();
    chk("t6_clr_wins", 32'(press_cnt), 32'd0);
    chk("t6_code",     32'(key_code),  32'h24);

    // Sticky overflow
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_ovf_set", 32'(ovf_seen), 32'd1);
    pulse_clr();
    chk("t7_ovf_clr", 32'(ovf_seen), 32'd0);
    overflow = 1'b1; clr_stat = 1'b1;
    @(negedge clk);
    overflow = 1'b0; clr_stat = 1'b0;
    @(negedge clk);
    chk("t7_clr_over_ovf", 32'(ovf_seen), 32'd0);

    // F0, reset, 15: the pending break must not survive reset
    push(8'hF0);
    wait_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t8_rst_down", 32'(key_down), 32'd0);
    chk("t8_rst_code", 32'(key_code), 32'd0);
    s_pr = n_press;
    push(8'h15);
    wait_idle();
    chk("t8_make_down",  32'(key_down), 32'd1);
    chk("t8_make_code",  32'(key_code), 32'h15);
    chk("t8_make_press", 32'(n_press - s_pr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the press counter.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ready  input  1  receiver FIFO non-empty; data valid while high.
REQ-005 SHALL have port data  input  8  FIFO head byte (scan code).
REQ-006 SHALL have port overflow  input  1  receiver FIFO overflow flag.
REQ-007 SHALL have port clr_stat  input  1  one-cycle clear of press_cnt and ovf_seen.
REQ-008 SHALL have port nextdata_n  output  1  active-low FIFO pop strobe to the receiver.
REQ-009 SHALL have port key_code  output  8  scan code of the current or last key.
REQ-010 SHALL have port key_ext  output  1  current or last key carried an E0 prefix.
REQ-011 SHALL have port key_down  output  1  the key in key_code/key_ext is held.
REQ-012 SHALL have port press_pulse  output  1  one-cycle strobe on a new make.
REQ-013 SHALL have port release_pulse  output  1  one-cycle strobe on a matching break.
REQ-014 SHALL have port press_cnt  output  CNT_W  count of new makes; wraps at max.
REQ-015 SHALL have port ovf_seen  output  1  sticky: overflow was observed high.

Function
REQ-016 FSM states SHALL be WAIT, POP and GAP.
REQ-017 In WAIT with ready=1, SHALL capture data, decode it and go to POP the next cycle.
REQ-018 In POP, nextdata_n SHALL be 0 for exactly one cycle, then go to GAP; nextdata_n = 1 in every other state.
REQ-019 GAP SHALL last one cycle so ready can settle, then return to WAIT; throughput is at most one byte per 3 cycles.
REQ-020 data and ready SHALL be ignored outside WAIT.
REQ-021 Byte F0 SHALL set brk_pend; byte E0 SHALL set ext_pend; neither SHALL change any outputs.
REQ-022 Bytes 00 and FF (PS/2 error codes) SHALL clear brk_pend and ext_pend and change no outputs.
REQ-023 Any other byte with brk_pend=0 is a make; with brk_pend=1 it is a break.
REQ-024 Both prefix flags SHALL clear after any non-prefix byte.
REQ-025 New make (key_down=0, or code/ext differ from current) SHALL load key_code and key_ext, set key_down, and pulse press_pulse one cycle after capture.
REQ-026 Repeated make identical to the held key (typematic) SHALL produce no pulse and no count.
REQ-027 Break matching key_code and key_ext with key_down=1 SHALL clear key_down and pulse release_pulse; key_code and key_ext SHALL be retained.
REQ-028 Non-matching break SHALL be ignored.
REQ-029 press_cnt SHALL increment by 1 with each press_pulse and wrap from 2^CNT_W-1 to 0.
REQ-030 ovf_seen SHALL set on any cycle with overflow=1 and clear only on clr_stat or reset.
REQ-031 clr_stat SHALL zero press_cnt and ovf_seen; it wins over a simultaneous increment or overflow.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 When rst=1: state=WAIT, nextdata_n=1, key_code=0, key_ext=0, key_down=0, press_pulse=0, release_pulse=0, press_cnt=0, ovf_seen=0, and both prefix flags cleared.
REQ-034 Reset asserted mid-sequence (e.g. in POP, or after F0) SHALL abandon the sequence, and the pending prefix SHALL NOT apply to later bytes.

Structure
REQ-035 A shared package ps2_pkg SHALL hold the state enum and the constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_ERR0=8'h00 and PS2_ERR1=8'hFF.
REQ-036 No sub-module SHALL be used; decode, FSM and counter all live in ps2_key_ctrl.

Verification
REQ-037 Stream 15, F0, 15 -> one press_pulse with key_code=15, key_ext=0, key_down 1 then 0, one release_pulse, press_cnt=1; nextdata_n low exactly 3 single cycles.
REQ-038 Stream 1C, 1C, 1C, F0, 1C -> press_cnt=1, one press_pulse, one release_pulse.
REQ-039 Stream E0, 75, E0, F0, 75 -> key_code=75, key_ext=1 pressed then released; a plain 75 afterwards counts as a new press.
REQ-040 With press_cnt=255, stream 23 -> press_cnt=0; clr_stat in the same cycle as a press_pulse -> press_cnt=0.
REQ-041 Pulse overflow for 1 cycle -> ovf_seen=1 until clr_stat; stream F0, rst, 15 -> treated as a make, key_down=1.
REQ-042 Hold ready=1 with 4 queued bytes -> exactly one nextdata_n low pulse per 3 cycles, and no byte is skipped or double-read.
